// File: rtl/ldm_stm_seq.sv
// LDM/STM/PUSH/POP sequencer: one word transfer per set mask bit, then base writeback.
// Latency: start at T -> first mem_req at T+1 -> done at T+cnt+1 with zero-wait memory.
// Backpressure: each transfer holds req/addr/reg until mem_ack; LDM_STM_TIMEOUT_EN adds a wait limit.
module ldm_stm_seq #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_load,
   input  logic [15:0] reg_mask,
   input  logic [31:0] base_addr,
   input  logic [3:0]  rn_addr,
   input  logic        add,
   input  logic        index,
   input  logic        wback,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic [31:0] rf_rdata,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  rf_addr,
   output logic        rf_w_en,
   output logic [31:0] rf_wdata,
   output logic        pc_load,
   output logic        wb_en,
   output logic [3:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        done,
   output logic        fault
);

   typedef enum logic [1:0] {IDLE, XFER, WBACK} state_t;

   state_t      state_q, state_d;
   logic        is_load_q, is_load_d;
   logic [15:0] mask_q, mask_d;       // registers still to transfer
   logic [3:0]  rn_q, rn_d;
   logic        wback_q, wback_d;
   logic        base_ld_q, base_ld_d; // base is overwritten by the load itself
   logic [31:0] addr_q, addr_d;
   logic [31:0] final_q, final_d;

   logic [4:0]  cnt;
   logic [31:0] offset;
   logic [3:0]  cur_reg;
   logic        timeout;

   // Number of registers in the incoming list
   always_comb begin
      cnt = '0;
      for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, reg_mask[i]};
   end

   assign offset = {25'd0, cnt, 2'b00};

   // Lowest-numbered remaining register goes out first, so it lands at the lowest address
   always_comb begin
      cur_reg = '0;
      for (int i = 15; i >= 0; i--) if (mask_q[i]) cur_reg = 4'(i);
   end

`ifdef LDM_STM_TIMEOUT_EN
   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
   logic [3:0] wait_q, wait_d;

   assign timeout = (state_q == XFER) && (wait_q == WAIT_LIM);

   always_comb begin
      wait_d = '0;
      if (state_q == XFER && !mem_ack && !timeout) wait_d = wait_q + 4'd1;
   end

   // Wait counter: cycles spent on the current transfer without an ack
   always_ff @(posedge clk) begin
      if (!rst) wait_q <= '0;
      else      wait_q <= wait_d;
   end
`else
   logic unused_max_wait;
   assign unused_max_wait = (MAX_WAIT != 0);
   assign timeout         = 1'b0;
`endif

   // State register and latched sequence context
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         is_load_q <= 1'b0;
         mask_q    <= '0;
         rn_q      <= '0;
         wback_q   <= 1'b0;
         base_ld_q <= 1'b0;
         addr_q    <= '0;
         final_q   <= '0;
      end else begin
         state_q   <= state_d;
         is_load_q <= is_load_d;
         mask_q    <= mask_d;
         rn_q      <= rn_d;
         wback_q   <= wback_d;
         base_ld_q <= base_ld_d;
         addr_q    <= addr_d;
         final_q   <= final_d;
      end
   end

   // Next-state and control outputs
   always_comb begin
      state_d   = state_q;
      is_load_d = is_load_q;
      mask_d    = mask_q;
      rn_d      = rn_q;
      wback_d   = wback_q;
      base_ld_d = base_ld_q;
      addr_d    = addr_q;
      final_d   = final_q;
      mem_req   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               is_load_d = is_load;
               mask_d    = reg_mask;
               rn_d      = rn_addr;
               wback_d   = wback;
               base_ld_d = is_load && reg_mask[rn_addr];
               if (add) addr_d = index ? base_addr + 32'd4 : base_addr;
               else     addr_d = index ? base_addr - offset : base_addr - offset + 32'd4;
               final_d   = add ? base_addr + offset : base_addr - offset;
               state_d   = (cnt == 5'd0) ? WBACK : XFER;
            end
         end
         XFER: begin
            if (timeout) begin
               // Abandon the sequence; loads already committed stay committed
               mask_d  = '0;
               state_d = IDLE;
            end else begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  mask_d = mask_q & (mask_q - 16'd1);
                  addr_d = addr_q + 32'd4;
                  if (mask_d == 16'd0) state_d = WBACK;
               end
            end
         end
         WBACK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign mem_we    = mem_req && !is_load_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = rf_rdata;
   assign rf_addr   = cur_reg;
   assign rf_w_en   = mem_req && mem_ack && is_load_q;
   assign rf_wdata  = mem_rdata;
   assign pc_load   = rf_w_en && (cur_reg == 4'd15);
   assign wb_en     = (state_q == WBACK) && wback_q && !base_ld_q;
   assign wb_addr   = rn_q;
   assign wb_data   = final_q;
   assign done      = (state_q == WBACK) || timeout;
   assign fault     = timeout;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: LDM/STM addressing modes, wait states, empty list, reset abort.
// Inputs are driven 1 ns after each rising edge, outputs sampled 4 ns after it.
// Memory ack is driven directly by the stimulus to model zero-wait and delayed responses.
module tb_ldm_stm_seq;

   logic        clk = 1'b0;
   logic        rst, start, is_load, add, index, wback, mem_ack;
   logic [15:0] reg_mask;
   logic [31:0] base_addr, mem_rdata, rf_rdata;
   logic [3:0]  rn_addr;
   logic        busy, mem_req, mem_we, rf_w_en, pc_load, wb_en, done, fault;
   logic [31:0] mem_addr, mem_wdata, rf_wdata, wb_data;
   logic [3:0]  rf_addr, wb_addr;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   ldm_stm_seq #(.MAX_WAIT(15)) dut (
      .clk(clk), .rst(rst), .start(start), .is_load(is_load), .reg_mask(reg_mask),
      .base_addr(base_addr), .rn_addr(rn_addr), .add(add), .index(index), .wback(wback),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_rdata(rf_rdata),
      .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .rf_addr(rf_addr), .rf_w_en(rf_w_en), .rf_wdata(rf_wdata),
      .pc_load(pc_load), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .done(done), .fault(fault)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xfer_chk(input string tag, input logic [31:0] a, input logic [3:0] r,
                           input logic we, input logic wen);
      chk({tag, ".req"},  {31'd0, mem_req}, 32'd1);
      chk({tag, ".addr"}, mem_addr, a);
      chk({tag, ".reg"},  {28'd0, rf_addr}, {28'd0, r});
      chk({tag, ".we"},   {31'd0, mem_we}, {31'd0, we});
      chk({tag, ".wen"},  {31'd0, rf_w_en}, {31'd0, wen});
      chk({tag, ".done"}, {31'd0, done}, 32'd0);
   endtask

   task automatic wb_chk(input string tag, input logic en, input logic [31:0] d, input logic [3:0] a);
      chk({tag, ".done"}, {31'd0, done}, 32'd1);
      chk({tag, ".req"},  {31'd0, mem_req}, 32'd0);
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      chk({tag, ".wben"}, {31'd0, wb_en}, {31'd0, en});
      if (en) begin
         chk({tag, ".wbdat"}, wb_data, d);
         chk({tag, ".wbadr"}, {28'd0, wb_addr}, {28'd0, a});
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
      chk({tag, ".done"}, {31'd0, done}, 32'd0);
      chk({tag, ".req"},  {31'd0, mem_req}, 32'd0);
      chk({tag, ".wben"}, {31'd0, wb_en}, 32'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; is_load = 1'b0; reg_mask = '0; base_addr = '0;
      rn_addr = '0; add = 1'b0; index = 1'b0; wback = 1'b0; mem_ack = 1'b0;
      mem_rdata = '0; rf_rdata = '0;

      // Reset state
      tick(); tick(); #3;
      idle_chk("rst");
      chk("rst.addr",  mem_addr, 32'd0);
      chk("rst.reg",   {28'd0, rf_addr}, 32'd0);
      chk("rst.fault", {31'd0, fault}, 32'd0);
      chk("rst.wen",   {31'd0, rf_w_en}, 32'd0);
      tick(); rst = 1'b1;

      // LDMIA r0!, {r1,r2,r4}, base 0x1000, zero-wait
      tick(); start = 1'b1; is_load = 1'b1; reg_mask = 16'h0016; base_addr = 32'h1000;
      rn_addr = 4'd0; add = 1'b1; index = 1'b0; wback = 1'b1; mem_ack = 1'b1;
      tick(); start = 1'b0; mem_rdata = 32'hAAAA_0001; #3;
      xfer_chk("t1b1", 32'h1000, 4'd1, 1'b0, 1'b1);
      chk("t1b1.rfwd", rf_wdata, 32'hAAAA_0001);
      chk("t1b1.busy", {31'd0, busy}, 32'd1);
      tick(); mem_rdata = 32'hAAAA_0002; #3;
      xfer_chk("t1b2", 32'h1004, 4'd2, 1'b0, 1'b1);
      tick(); mem_rdata = 32'hAAAA_0004; #3;
      xfer_chk("t1b3", 32'h1008, 4'd4, 1'b0, 1'b1);
      chk("t1b3.pc", {31'd0, pc_load}, 32'd0);
      tick(); #3;
      wb_chk("t1wb", 1'b1, 32'h100C, 4'd0);
      tick(); #3;
      idle_chk("t1end");

      // STMDB r13!, {r4,r5,r14}, base 0x2000
      tick(); start = 1'b1; is_load = 1'b0; reg_mask = 16'h4030; base_addr = 32'h2000;
      rn_addr = 4'd13; add = 1'b0; index = 1'b1; wback = 1'b1; mem_ack = 1'b1;
      tick(); start = 1'b0; rf_rdata = 32'h5555_0004; #3;
      xfer_chk("t2b1", 32'h1FF4, 4'd4, 1'b1, 1'b0);
      chk("t2b1.wd", mem_wdata, 32'h5555_0004);
      tick(); rf_rdata = 32'h5555_0005; #3;
      xfer_chk("t2b2", 32'h1FF8, 4'd5, 1'b1, 1'b0);
      tick(); rf_rdata = 32'h5555_000E; #3;
      xfer_chk("t2b3", 32'h1FFC, 4'd14, 1'b1, 1'b0);
      chk("t2b3.wd", mem_wdata, 32'h5555_000E);
      tick(); #3;
      wb_chk("t2wb", 1'b1, 32'h1FF4, 4'd13);
      tick(); #3;
      idle_chk("t2end");

      // LDMIA r1!, {r1,r2}, three wait cycles per beat, base in list, start while busy
      tick(); start = 1'b1; is_load = 1'b1; reg_mask = 16'h0006; base_addr = 32'h3000;
      rn_addr = 4'd1; add = 1'b1; index = 1'b0; wback = 1'b1; mem_ack = 1'b0;
      tick(); start = 1'b0; #3;
      xfer_chk("t3w1", 32'h3000, 4'd1, 1'b0, 1'b0);
      tick(); start = 1'b1; reg_mask = 16'hFFFF; #3;
      xfer_chk("t3w2", 32'h3000, 4'd1, 1'b0, 1'b0);
      tick(); start = 1'b0; #3;
      xfer_chk("t3w3", 32'h3000, 4'd1, 1'b0, 1'b0);
      tick(); mem_ack = 1'b1; mem_rdata = 32'h0000_3001; #3;
      xfer_chk("t3a1", 32'h3000, 4'd1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick(); mem_ack = 1'b0; #3;
         xfer_chk("t3w", 32'h3004, 4'd2, 1'b0, 1'b0);
      end
      tick(); mem_ack = 1'b1; #3;
      xfer_chk("t3a2", 32'h3004, 4'd2, 1'b0, 1'b1);
      tick(); #3;
      wb_chk("t3wb", 1'b0, 32'h0, 4'd0);
      tick(); #3;
      idle_chk("t3end");

      // Empty list; start held high through the busy cycle
      tick(); start = 1'b1; is_load = 1'b0; reg_mask = 16'h0000; base_addr = 32'h4444;
      rn_addr = 4'd5; add = 1'b1; wback = 1'b1; mem_ack = 1'b1;
      tick(); #3;
      wb_chk("t4wb", 1'b1, 32'h4444, 4'd5);
      tick(); start = 1'b0; #3;
      idle_chk("t4end");

      // LDMDA r2!, {r0,pc}, base 0x4000: pc_load on the r15 beat
      tick(); start = 1'b1; is_load = 1'b1; reg_mask = 16'h8001; base_addr = 32'h4000;
      rn_addr = 4'd2; add = 1'b0; index = 1'b0; wback = 1'b1; mem_ack = 1'b1;
      tick(); start = 1'b0; #3;
      xfer_chk("t5b1", 32'h3FFC, 4'd0, 1'b0, 1'b1);
      chk("t5b1.pc", {31'd0, pc_load}, 32'd0);
      tick(); #3;
      xfer_chk("t5b2", 32'h4000, 4'd15, 1'b0, 1'b1);
      chk("t5b2.pc", {31'd0, pc_load}, 32'd1);
      tick(); #3;
      wb_chk("t5wb", 1'b1, 32'h3FF8, 4'd2);
      tick(); #3;
      idle_chk("t5end");

      // LDMIB r4!, {r4-r7}, reset during beat 2, then a fresh sequence
      tick(); start = 1'b1; is_load = 1'b1; reg_mask = 16'h00F0; base_addr = 32'h5000;
      rn_addr = 4'd4; add = 1'b1; index = 1'b1; wback = 1'b1; mem_ack = 1'b1;
      tick(); start = 1'b0; #3;
      xfer_chk("t6b1", 32'h5004, 4'd4, 1'b0, 1'b1);
      tick(); rst = 1'b0; #3;
      xfer_chk("t6b2", 32'h5008, 4'd5, 1'b0, 1'b1);
      tick(); rst = 1'b1; #3;
      idle_chk("t6rst");
      chk("t6rst.addr", mem_addr, 32'd0);
      chk("t6rst.reg",  {28'd0, rf_addr}, 32'd0);
      tick(); start = 1'b1; reg_mask = 16'h0008;
      tick(); start = 1'b0; #3;
      xfer_chk("t6n1", 32'h5004, 4'd3, 1'b0, 1'b1);
      tick(); #3;
      wb_chk("t6wb", 1'b1, 32'h5004, 4'd4);
      tick(); #3;
      idle_chk("t6end");

`ifdef LDM_STM_TIMEOUT_EN
      // Ack never arrives: fault and done 15 cycles after mem_req rises
      tick(); start = 1'b1; is_load = 1'b1; reg_mask = 16'h0001; base_addr = 32'h6000;
      rn_addr = 4'd3; add = 1'b1; index = 1'b0; wback = 1'b1; mem_ack = 1'b0;
      tick(); start = 1'b0; #3;
      for (int k = 0; k < 15; k++) begin
         xfer_chk("t7w", 32'h6000, 4'd0, 1'b0, 1'b0);
         chk("t7w.fault", {31'd0, fault}, 32'd0);
         tick(); #3;
      end
      chk("t7.fault", {31'd0, fault}, 32'd1);
      chk("t7.done",  {31'd0, done}, 32'd1);
      chk("t7.req",   {31'd0, mem_req}, 32'd0);
      chk("t7.wben",  {31'd0, wb_en}, 32'd0);
      tick(); #3;
      idle_chk("t7end");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ldm_stm_seq.md
Name: ldm_stm_seq

Overview:
- Multi-cycle sequencer for load-multiple/store-multiple (LDM/STM/PUSH/POP) in the ARM core.
- Sits in stage two beside reg_file.
- Takes the decoded register mask, base value and addressing flags, then issues one word transfer per register to the data-memory port.
- Drives the register-file read/write address and holds the pipeline stalled until the sequence and base writeback complete.

Parameters:
- MAX_WAIT, 15: maximum wait cycles for mem_ack per transfer (used only with the optional feature).

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to begin a sequence (decoder asserts for LDM/STM)
- is_load  input  1  1 = LDM/POP, 0 = STM/PUSH
- reg_mask  input  16  register list, bit n = Rn
- base_addr  input  32  current value of base register Rn
- rn_addr  input  4  base register number
- add  input  1  1 = increment, 0 = decrement
- index  input  1  1 = before, 0 = after
- wback  input  1  base writeback requested
- mem_ack  input  1  memory accepted/completed current transfer
- mem_rdata  input  32  load data, valid with mem_ack
- rf_rdata  input  32  register-file read data for rf_addr
- busy  output  1  sequence in progress; stalls fetch/decode
- mem_req  output  1  transfer request
- mem_we  output  1  1 = write (store)
- mem_addr  output  32  word address of current transfer
- mem_wdata  output  32  store data (combinational copy of rf_rdata)
- rf_addr  output  4  register currently transferred
- rf_w_en  output  1  load write enable (mem_ack & is_load in XFER)
- rf_wdata  output  32  = mem_rdata
- pc_load  output  1  pulse when R15 is loaded
- wb_en  output  1  base writeback strobe
- wb_addr  output  4  = latched rn_addr
- wb_data  output  32  final base value
- done  output  1  one-cycle completion pulse
- fault  output  1  timeout pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (rst=0 at edge): state IDLE; all registered outputs 0, mem_addr 0, rf_addr 0. Reset mid-sequence aborts immediately; no wb_en or done.
- States are IDLE, XFER, WBACK.
- IDLE: on start, latch is_load, mask, rn_addr, add, index, wback; compute cnt = popcount(mask) (0..16).
  - Start address: IA = base; IB = base+4; DA = base-4*cnt+4; DB = base-4*cnt (32-bit wrap).
  - Final base: add ? base+4*cnt : base-4*cnt.
  - cnt≠0 → XFER; cnt=0 → WBACK.
- XFER: mem_req=1, rf_addr = lowest set bit of remaining mask, mem_addr = current address.
  - Request, address and register are held stable until mem_ack; ack may arrive in the same cycle as the request.
  - On ack: clear that mask bit, address += 4.
  - If the mask becomes empty → WBACK; otherwise the next register is issued the following cycle.
  - Lowest-numbered register always goes to the lowest address.
- WBACK (1 cycle): done=1, busy deasserted next cycle.
  - wb_en=1 iff wback && !(is_load && mask[rn]). The loaded value wins when the base is in a load list.
  - For a store with the base in the list, the original base value is stored.
- Latency with zero-wait memory: start at T, first mem_req at T+1, done at T+cnt+1; busy high T+1..T+cnt+1.
- start while busy is ignored.
- pc_load pulses with rf_w_en when rf_addr=15.
- An empty mask produces no memory traffic; done still pulses at T+1, and wb_en follows the rule above (base unchanged).

Optional Feature:
- Macro LDM_STM_TIMEOUT_EN.
- Defined: a 4-bit wait counter runs in XFER and clears on each ack. On reaching MAX_WAIT without ack: drop mem_req, pulse fault and done together, suppress wb_en, return to IDLE. Loads already written stay written.
- Undefined: no counter, fault tied 0, XFER waits indefinitely.

Test Plan:
- LDMIA r0!, mask 0x0016, base 0x1000, zero-wait → rf writes r1@0x1000, r2@0x1004, r4@0x1008; wb_en with wb_data 0x100C; done at T+4.
- STMDB r13!, mask 0x4030, base 0x2000 → stores r4@0x1FF4, r5@0x1FF8, r14@0x1FFC, all mem_we=1; wb_data 0x1FF4.
- LDMIA r1!, mask 0x0006, ack delayed 3 cycles per beat → address and rf_addr held stable; r1 loaded from 0x…+0; wb_en=0.
- Empty mask, and start repeated while busy → done at T+1 with no mem_req; the second start is ignored.
- rst=0 asserted during beat 2 of a 4-register load → next cycle busy=0, mem_req=0, no done, no wb_en; a new start works normally.
- With LDM_STM_TIMEOUT_EN and MAX_WAIT=15, ack never arrives → fault and done pulse 15 cycles after mem_req rises; wb_en=0.
